// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - state encoding and counter sizing for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_HOLD       = 3'd1,
    ST_PERIPH_REL = 3'd2,
    ST_RUN        = 3'd3,
    ST_SW_RST     = 3'd4
  } state_e;

  // Wide enough for the largest terminal count (N-1); never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return int'($clog2(m));
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// rtl/rst_sync_2ff.sv - two-flop reset synchroniser, async assert, clock-synchronous release
module rst_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_no = sync_q[1];

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - ordered reset release (peripherals, then core) with software warm reset
module rst_seq #(
  parameter int unsigned HoldCycles    = 16,
  parameter int unsigned StaggerCycles = 4,
  parameter int unsigned SwRstCycles   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_rst_req_i,
  output logic rst_periph_no,
  output logic rst_core_no,
  output logic rst_done_o,
  output logic rst_cause_sw_o
);
  import rst_seq_pkg::*;

  localparam int unsigned CntW = cnt_width(HoldCycles, StaggerCycles, SwRstCycles);
  localparam logic [CntW-1:0] HoldLast    = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(StaggerCycles - 1);
  localparam logic [CntW-1:0] SwRstLast   = CntW'(SwRstCycles - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            periph_q, periph_d;
  logic            core_q, core_d;
  logic            done_q, done_d;
  logic            cause_q, cause_d;
  logic            rst_sync;

  rst_sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rst_no (rst_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_RESET: begin
        if (rst_sync) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HoldLast) begin
          state_d = ST_PERIPH_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_PERIPH_REL: begin
        if (cnt_q == StaggerLast) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_RUN: begin
        if (sw_rst_req_i) begin
          state_d = ST_SW_RST;
          cnt_d   = '0;
          cause_d = 1'b1;
        end
      end
      ST_SW_RST: begin
        if (cnt_q == SwRstLast) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    periph_d = (state_d == ST_PERIPH_REL) || (state_d == ST_RUN);
    core_d   = (state_d == ST_RUN);
    done_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      done_q   <= 1'b0;
      cause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
    end
  end

  assign rst_periph_no  = periph_q;
  assign rst_core_no    = core_q;
  assign rst_done_o     = done_q;
  assign rst_cause_sw_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - bench for rst_seq: default and minimum-parameter instances vs a timing model
module tb_rst_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_req, sw_min;
  logic periph, core, done, cause;
  logic periph_m, core_m, done_m, cause_m;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rst_seq #(.HoldCycles(16), .StaggerCycles(4), .SwRstCycles(8)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sw_rst_req_i   (sw_req),
    .rst_periph_no  (periph),
    .rst_core_no    (core),
    .rst_done_o     (done),
    .rst_cause_sw_o (cause)
  );

  rst_seq #(.HoldCycles(1), .StaggerCycles(1), .SwRstCycles(1)) u_dut_min (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sw_rst_req_i   (sw_min),
    .rst_periph_no  (periph_m),
    .rst_core_no    (core_m),
    .rst_done_o     (done_m),
    .rst_cause_sw_o (cause_m)
  );

  // Model: edges elapsed since the last anchor (raw release or accepted software request).
  int p_h[2] = '{16, 1};
  int p_s[2] = '{4, 1};
  int p_w[2] = '{8, 1};
  int m_n[2];
  bit m_sw[2];

  function automatic int rel_base(input int d);
    return m_sw[d] ? (p_w[d] + p_h[d]) : (3 + p_h[d]);
  endfunction

  function automatic bit exp_periph(input int d);
    return m_n[d] >= rel_base(d);
  endfunction

  function automatic bit exp_core(input int d);
    return m_n[d] >= rel_base(d) + p_s[d];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_n[d]  <= 0;
        m_sw[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (exp_core(d) && ((d == 0) ? sw_req : sw_min)) begin
          m_n[d]  <= 0;
          m_sw[d] <= 1'b1;
        end else if (m_n[d] < 100000) begin
          m_n[d] <= m_n[d] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("model_periph", periph, exp_periph(0));
    chk("model_core", core, exp_core(0));
    chk("model_done", done, exp_core(0));
    chk("model_cause", cause, m_sw[0]);
    chk("model_min_periph", periph_m, exp_periph(1));
    chk("model_min_core", core_m, exp_core(1));
    chk("model_min_done", done_m, exp_core(1));
    chk("model_min_cause", cause_m, m_sw[1]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_periph"}, periph, 1'b0);
    chk({tag, "_core"}, core, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cause"}, cause, 1'b0);
    chk({tag, "_min_periph"}, periph_m, 1'b0);
    chk({tag, "_min_core"}, core_m, 1'b0);
    chk({tag, "_min_cause"}, cause_m, 1'b0);
  endtask

  // Raw reset for 5 cycles then release; pulse_edge > 0 injects an ignored request.
  task automatic power_on_seq(input int pulse_edge);
    rst_n = 1'b0;
    repeat (5) tick();
    chk_all_low("por_reset");
    rst_n = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      sw_req = (i == pulse_edge);
      tick();
      if (i == 3)  chk("min_periph_e3", periph_m, 1'b0);
      if (i == 4)  begin chk("min_periph_e4", periph_m, 1'b1); chk("min_core_e4", core_m, 1'b0); end
      if (i == 5)  begin chk("min_core_e5", core_m, 1'b1); chk("min_done_e5", done_m, 1'b1); end
      if (i == 18) chk("por_periph_e18", periph, 1'b0);
      if (i == 19) begin chk("por_periph_e19", periph, 1'b1); chk("por_core_e19", core, 1'b0); end
      if (i == 22) begin chk("por_core_e22", core, 1'b0); chk("por_done_e22", done, 1'b0); end
      if (i == 23) begin
        chk("por_core_e23", core, 1'b1);
        chk("por_done_e23", done, 1'b1);
        chk("por_cause_e23", cause, 1'b0);
      end
    end
    sw_req = 1'b0;
  endtask

  // Software reset from Run at edge k; extra > 0 adds an ignored request at edge k+extra.
  task automatic sw_seq(input int extra);
    sw_req = 1'b1;
    sw_min = 1'b1;
    tick();
    sw_req = 1'b0;
    sw_min = 1'b0;
    chk("sw_periph_k", periph, 1'b0);
    chk("sw_core_k", core, 1'b0);
    chk("sw_done_k", done, 1'b0);
    chk("sw_cause_k", cause, 1'b1);
    chk("min_sw_periph_k", periph_m, 1'b0);
    chk("min_sw_cause_k", cause_m, 1'b1);
    for (int j = 1; j <= 28; j++) begin
      sw_req = (j == extra);
      tick();
      if (j == 1)  begin chk("min_sw_periph_k1", periph_m, 1'b0); chk("min_sw_core_k1", core_m, 1'b0); end
      if (j == 2)  begin chk("min_sw_periph_k2", periph_m, 1'b1); chk("min_sw_core_k2", core_m, 1'b0); end
      if (j == 3)  chk("min_sw_core_k3", core_m, 1'b1);
      if (j == 23) chk("sw_periph_k23", periph, 1'b0);
      if (j == 24) begin chk("sw_periph_k24", periph, 1'b1); chk("sw_core_k24", core, 1'b0); end
      if (j == 27) chk("sw_core_k27", core, 1'b0);
      if (j == 28) begin
        chk("sw_core_k28", core, 1'b1);
        chk("sw_done_k28", done, 1'b1);
        chk("sw_cause_k28", cause, 1'b1);
      end
    end
    sw_req = 1'b0;
  endtask

  task automatic abort_at(input int e);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (e) tick();
    if (e >= 19) chk("abort_pre_periph", periph, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_low("abort_async");
  endtask

  initial begin
    int last_rise, rises, last_rise_m, rises_m;
    logic prev_done, prev_done_m, hold_req;

    rst_n  = 1'b0;
    sw_req = 1'b0;
    sw_min = 1'b0;

    power_on_seq(0);
    sw_seq(0);

    rst_n = 1'b0;
    #1;
    chk_all_low("run_async");

    power_on_seq(8);
    sw_seq(3);

    abort_at(10);
    power_on_seq(0);
    abort_at(21);
    power_on_seq(0);

    last_rise = -1; rises = 0; prev_done = 1'b0;
    last_rise_m = -1; rises_m = 0; prev_done_m = 1'b0;
    sw_req = 1'b1;
    sw_min = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (done) begin
        chk("held_width", prev_done, 1'b0);
        if (last_rise >= 0) chk("held_period", (i - last_rise) == 29, 1'b1);
        last_rise = i;
        rises++;
      end
      if (done_m) begin
        chk("min_held_width", prev_done_m, 1'b0);
        if (last_rise_m >= 0) chk("min_held_period", (i - last_rise_m) == 4, 1'b1);
        last_rise_m = i;
        rises_m++;
      end
      prev_done = done;
      prev_done_m = done_m;
    end
    chk("held_rises", rises >= 4, 1'b1);
    chk("min_held_rises", rises_m >= 20, 1'b1);
    sw_req = 1'b0;
    sw_min = 1'b0;

    hold_req = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) < 3) hold_req = ~hold_req;
      sw_req = hold_req | ($urandom_range(0, 19) == 0);
      sw_min = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer downstream of the FPGA clock generator. Takes the system clock and the raw combined reset (PLL lock AND board reset) and produces glitch-free, clock-synchronous reset releases in a fixed order: peripherals first, core last. It also provides a software-triggered warm reset and records the cause of the last reset. All other system logic takes its reset from this block, never from the raw reset.

## Interface
Parameters:
- HoldCycles, default 16: cycles held in reset after synchronised release, before the peripheral release; must be ≥ 1.
- StaggerCycles, default 4: cycles between peripheral release and core release; must be ≥ 1.
- SwRstCycles, default 8: minimum assertion length of a software reset; must be ≥ 1.

Ports:
- clk_i, in, 1: system clock (clk_sys).
- rst_ni, in, 1: raw reset (rst_sys_n). Single clock; reset is asynchronous and active-low.
- sw_rst_req_i, in, 1: software warm-reset request, level-sampled, synchronous to clk_i.
- rst_periph_no, out, 1: peripheral reset, active-low, registered.
- rst_core_no, out, 1: core reset, active-low, registered.
- rst_done_o, out, 1: high only in Run.
- rst_cause_sw_o, out, 1: 1 if the most recent reset was a software reset; 0 after a power-on or raw reset.

## Operation
- **Raw reset.** rst_ni low asynchronously clears every flop.
  - Outputs during reset: rst_periph_no=0, rst_core_no=0, rst_done_o=0, rst_cause_sw_o=0.
  - FSM state is Reset and the counter is 0.
- **Synchroniser.** A 2-flop synchroniser is async-cleared by rst_ni and has constant 1 at its D input. Its output rst_sync rises after the 2nd clk_i edge following rst_ni deassertion.
- **FSM states** (one-hot or binary; encoding is free):
  - Reset: both resets asserted. Go to Hold when rst_sync=1, clearing the counter.
  - Hold: both resets asserted. Counter increments each cycle. When counter == HoldCycles-1, go to PeriphRel, clear the counter, and set rst_periph_no=1.
  - PeriphRel: rst_periph_no=1, rst_core_no=0. When counter == StaggerCycles-1, go to Run and set rst_core_no=1.
  - Run: both resets released and rst_done_o=1. If sw_rst_req_i=1 at an edge, go to SwRst: both resets 0, rst_done_o 0, counter cleared, rst_cause_sw_o set to 1.
  - SwRst: both resets asserted. When counter == SwRstCycles-1, go to Hold with the counter cleared. The sequence then repeats Hold → PeriphRel → Run.
- **sw_rst_req_i outside Run** is ignored. Requests are not queued.
- **sw_rst_req_i held high continuously** gives a repeated warm-reset loop. Each pass through Run lasts exactly 1 cycle before re-entering SwRst.
- **rst_ni low in any state, including mid-sequence** causes immediate async return to the reset values. rst_cause_sw_o clears to 0.
- **Counter width** is $clog2(max(HoldCycles, StaggerCycles, SwRstCycles)). The counter must never wrap; each exit compare precedes the maximum count.

## Timing
- Edge numbering: edge 1 is the first rising clk_i edge with rst_ni high.
  - rst_sync=1 after edge 2.
  - Reset→Hold at edge 3.
  - rst_periph_no rises after edge 3+HoldCycles.
  - rst_core_no and rst_done_o rise after edge 3+HoldCycles+StaggerCycles.
- All output rises are synchronous to clk_i. Outputs fall asynchronously on rst_ni, and synchronously on a software reset.
- Software reset: request sampled at edge k. Both resets are low from just after edge k.
  - Both resets are low for SwRstCycles+HoldCycles cycles in total.
  - Periph releases after edge k+SwRstCycles+HoldCycles.
  - Core releases StaggerCycles later.
- No combinational path from any input to any output.

## Structure
- rst_seq_pkg holds the state enum (Reset, Hold, PeriphRel, Run, SwRst) and the counter-width helper function.
- Sub-module rst_sync_2ff: a generic 2-flop async-clear synchroniser. It is reused later for other reset domains.
- The FSM, counter and output registers live in rst_seq.

## Test plan
- **Power-on.** Defaults; rst_ni low 5 cycles then high.
  - rst_periph_no rises after edge 19.
  - rst_core_no and rst_done_o rise after edge 23.
  - rst_cause_sw_o = 0.
- **Software reset.** In Run, 1-cycle sw_rst_req_i pulse at edge k.
  - Both resets low from edge k.
  - Periph high after edge k+24, core high after edge k+28.
  - rst_cause_sw_o = 1.
- **Reset mid-sequence.** rst_ni pulled low at edge 10 (Hold), then at edge 21 (PeriphRel).
  - Outputs return to reset values immediately, without waiting for a clock.
  - Full sequence restarts on re-release with identical timing.
- **Request outside Run.** sw_rst_req_i pulsed during Hold and again during SwRst.
  - No effect: release timing is unchanged and the cause reflects only accepted requests.
- **Held request.** sw_rst_req_i held high.
  - rst_done_o pulses high for exactly 1 cycle every SwRstCycles+HoldCycles+StaggerCycles+1 = 29 cycles.
- **Minimum parameters.** Hold=Stagger=SwRst=1.
  - Periph rises after edge 4, core after edge 5.
  - Software reset holds both resets low for exactly 2 cycles.
  - No counter overflow.
